vga_sync_gen: RTL

VGA timing generator for the maze display pipeline. It sits directly downstream of the pixel-rate divider and consumes that divider's 25 MHz pixel tick as a clock enable. It produces horizontal and vertical sync, a visible-area flag, and the current pixel coordinates for the maze/sprite renderer. Default timing is 640x480 @ 60 Hz; all timing values are parameters.

---
 rtl/vga_sync_gen.sv | 98 +++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel-rate
// clock enable, with registered sync, visible-area and frame-start outputs.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FRONT + V_SYNC;

  logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
  logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;
  logic [31:0]      x_ext, y_ext;

  // Next-state counters, plus decode from the next-state values so every
  // output lands on the same edge as the coordinates it describes.
  // Decode compares in 32 bits so a sync window ending exactly at 2^CNT_W
  // cannot wrap to zero.
  always_comb begin
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = '0;
        if (pixel_y_q == V_LAST) begin
          pixel_y_d     = '0;
          frame_start_d = 1'b1;
        end else begin
          pixel_y_d = pixel_y_q + CNT_W'(1);
        end
      end else begin
        pixel_x_d = pixel_x_q + CNT_W'(1);
      end
    end
    x_ext      = 32'(pixel_x_d);
    y_ext      = 32'(pixel_y_d);
    hsync_d    = !((x_ext >= H_SYNC_START) && (x_ext < H_SYNC_END));
    vsync_d    = !((y_ext >= V_SYNC_START) && (y_ext < V_SYNC_END));
    video_on_d = (x_ext < H_VISIBLE) && (y_ext < V_VISIBLE);
  end

  // State register; reset parks the raster at (0,0) with syncs idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule
